arithmetic_decoder: RTL and testbench
=====================================

// Module: arithmetic_decoder
// PURPOSE
//  AV1-style multi-symbol range decoder (od_ec_decode_cdf_q15 semantics), inverse of arithmetic_encoder.
//  Consumes the encoder's byte stream through a valid/ready port and returns one symbol per request.
//  Reads inverse-CDF (icdf) values from an external combinational LUT.
//  Sits between the bitstream buffer and the symbol consumer; shares the encoder's probability constants.
// PARAMETERS
//  GENERAL_DATA_16       16  range / icdf width
//  GENERAL_DATA_32       32  dif window width (WINDOW)
//  GENERAL_SYMBOL_WIDTH  4   symbol index width; nsyms up to 2**GENERAL_SYMBOL_WIDTH
//  GENERAL_CNT_WIDTH     8   signed cnt register width
// PORTS
//  general_clk    in   1     clock, all state on rising edge
//  reset          in   1     asynchronous, active-low; clears all state
//  init           in   1     one-cycle pulse: start a new stream (honoured in any state)
//  in_byte        in   8     stream byte
//  in_valid       in   1     in_byte valid
//  in_last        in   1     qualifies in_byte as final stream byte
//  in_ready       out  1     byte accepted when in_valid & in_ready
//  sym_req        in   1     decode request; accepted when sym_req & req_ready
//  general_nsyms  in   SW+1  alphabet size (2..2**SW), sampled on acceptance
//  req_ready      out  1     high only in READY
//  cdf_addr       out  SW    candidate index ret
//  cdf_data       in   16    icdf[cdf_addr], same cycle (combinational)
//  sym_out        out  SW    decoded symbol, held until next sym_valid
//  sym_valid      out  1     one-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE, dif=0, rng=0x8000, cnt=-15, eos=0; all outputs 0.
//  FSM: IDLE -init-> REFILL -> READY -sym_req-> SEARCH -hit-> RENORM -> (cnt<0 ? REFILL : READY).
//  init: dif=2**(WINDOW-1)-1, rng=0x8000, cnt=-15, eos=0, then REFILL.
//  REFILL: s = WINDOW-9-(cnt+15); while s>=0: dif ^= byte<<s; s-=8; cnt+=8.
//   - One byte per cycle; in_ready=1 only in REFILL with eos=0. Stalls while in_valid=0.
//   - Accepting in_last sets eos. With eos=1, missing bytes are 0x00 and consume one cycle each.
//   - Exits to READY when s<0.
//  SEARCH (one candidate per cycle; ret starts at 0): c = dif[WINDOW-1 -: 16]; N = nsyms-1.
//   - v_ret = ((rng>>8)*(cdf_data>>6))>>1 + 4*(N-ret); u = v_(ret-1), with u = rng at ret=0.
//   - Hit when c >= v_ret. ret=N always hits (icdf[N]=0 gives v=0). Latency 1..nsyms cycles.
//   - Products are 8x10 bit, 17-bit result; no truncation.
//  On hit: rng = u - v; dif -= v<<(WINDOW-16); sym_out = ret.
//  RENORM (1 cycle, registered) sets sym_valid=1:
//   - d = 15 - msb(rng); rng <<= d; dif = ((dif+1)<<d)-1 (mod 2**WINDOW); cnt -= d.
//  Boundaries:
//   - sym_req outside READY is ignored, not queued.
//   - init during SEARCH/RENORM aborts it; no sym_valid.
//   - init during REFILL drops the partial byte sequence.
//   - nsyms<2 is illegal (assertion).
// CONFIGURATION
//  ARITH_DECODER_DEBUG_EN defined: adds outputs RANGE_OUTPUT[15:0], DIF_OUTPUT[31:0], CNT_OUTPUT[31:0].
//   - All three are registered copies of rng/dif/cnt (sign-extended), updated every cycle.
//  Undefined: these ports and registers do not exist. Decode behaviour is identical either way.
// STRUCTURE
//  arith_pkg holds:
//   - EC_PROB_SHIFT=6, EC_MIN_PROB=4, EC_WINDOW=32
//   - dec_state_t enum {IDLE,REFILL,READY,SEARCH,RENORM}
//   - function clz16.
//  Sub-module arith_dec_renorm (combinational: rng, dif, cnt -> normalized rng, dif, cnt, d); FSM stays top.
// TESTING
//  Zero stream: init, bytes 00 00 00 -> cnt=9, dif=0x7FFFFFFF, req_ready=1 after 3 byte cycles.
//  Decode A: then nsyms=2, icdf={16384,0} -> sym_out=0 after 1 SEARCH cycle.
//   - Expect rng=0xFFF0, dif=0xFFEFFFFF, cnt=7; no refill.
//  Ones stream: init, bytes FF FF FF -> dif=0x0000007F.
//   - nsyms=4, icdf={24576,16384,8192,0} -> 4 SEARCH cycles, sym_out=3.
//  Backpressure: deassert in_valid 5 cycles mid-REFILL -> in_ready stays 1, state unchanged, no byte lost.
//  EOS: send 1 byte with in_last, then in_valid=0 -> refill completes with 0x00 padding; READY in 3 cycles.
//  Abort: reset low during SEARCH -> all outputs 0 immediately (async); init -> fresh stream decodes as in Decode A.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared constants, FSM state type and helpers for the arithmetic decoder.
// The probability constants match those of arithmetic_encoder.
package arith_pkg;

  localparam int unsigned GENERAL_DATA_16      = 16;
  localparam int unsigned GENERAL_DATA_32      = 32;
  localparam int unsigned GENERAL_SYMBOL_WIDTH = 4;
  localparam int unsigned GENERAL_CNT_WIDTH    = 8;

  localparam int unsigned EC_PROB_SHIFT = 6;
  localparam int unsigned EC_MIN_PROB   = 4;
  localparam int unsigned EC_WINDOW     = GENERAL_DATA_32;

  // Width of a normalisation shift amount (0..16).
  localparam int unsigned SHIFT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    REFILL,
    READY,
    SEARCH,
    RENORM
  } dec_state_t;

  // Leading-zero count of a 16-bit value; returns 16 for zero.
  function automatic logic [SHIFT_W-1:0] clz16(input logic [15:0] x);
    logic [SHIFT_W-1:0] n;
    n = SHIFT_W'(16);
    for (int i = 0; i < 16; i++) begin
      if (x[i]) n = SHIFT_W'(15 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/arith_dec_renorm.sv
// Combinational renormalisation step of the range decoder.
// Ports: rng_i/dif_i/cnt_i current state; rng_o/dif_o/cnt_o normalised
// state; d_o shift amount applied (16 only for an all-zero range).
module arith_dec_renorm
  import arith_pkg::*;
(
  input  logic        [GENERAL_DATA_16-1:0]   rng_i,
  input  logic        [GENERAL_DATA_32-1:0]   dif_i,
  input  logic signed [GENERAL_CNT_WIDTH-1:0] cnt_i,
  output logic        [GENERAL_DATA_16-1:0]   rng_o,
  output logic        [GENERAL_DATA_32-1:0]   dif_o,
  output logic signed [GENERAL_CNT_WIDTH-1:0] cnt_o,
  output logic        [SHIFT_W-1:0]           d_o
);

  localparam int unsigned WW = GENERAL_DATA_32;
  localparam int unsigned CW = GENERAL_CNT_WIDTH;

  // Ones are shifted into the bottom of dif so the window stays "all-ones padded".
  always_comb begin
    d_o   = clz16(rng_i);
    rng_o = rng_i << d_o;
    dif_o = ((dif_i + WW'(1)) << d_o) - WW'(1);
    cnt_o = cnt_i - CW'(d_o);
  end

endmodule

// File: rtl/arithmetic_decoder.sv
// AV1-style multi-symbol range decoder (od_ec_decode_cdf_q15 semantics).
// Ports: general_clk/reset (async, active-low); init starts a new stream;
// in_byte/in_valid/in_last/in_ready byte input; sym_req/general_nsyms/req_ready
// decode request; cdf_addr/cdf_data external combinational icdf LUT;
// sym_out/sym_valid decoded symbol.
// Optional macro ARITH_DECODER_DEBUG_EN adds RANGE_OUTPUT, DIF_OUTPUT and
// CNT_OUTPUT, registered copies of the internal rng/dif/cnt.
module arithmetic_decoder
  import arith_pkg::*;
(
  input  logic                            general_clk,
  input  logic                            reset,
  input  logic                            init,
  input  logic [7:0]                      in_byte,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  input  logic                            sym_req,
  input  logic [GENERAL_SYMBOL_WIDTH:0]   general_nsyms,
  output logic                            req_ready,
  output logic [GENERAL_SYMBOL_WIDTH-1:0] cdf_addr,
  input  logic [GENERAL_DATA_16-1:0]      cdf_data,
  output logic [GENERAL_SYMBOL_WIDTH-1:0] sym_out,
  output logic                            sym_valid
`ifdef ARITH_DECODER_DEBUG_EN
  ,
  output logic [15:0]                     RANGE_OUTPUT,
  output logic [31:0]                     DIF_OUTPUT,
  output logic [31:0]                     CNT_OUTPUT
`endif
);

  localparam int unsigned DW  = GENERAL_DATA_16;
  localparam int unsigned WW  = GENERAL_DATA_32;
  localparam int unsigned SW  = GENERAL_SYMBOL_WIDTH;
  localparam int unsigned NSW = SW + 1;
  localparam int unsigned CW  = GENERAL_CNT_WIDTH;
  localparam int unsigned SHW = CW + 1;
  localparam int unsigned PW  = 18;
  localparam int unsigned VW  = 17;
  localparam int unsigned REFILL_TOP = WW - 24;

  localparam logic        [DW-1:0]  RNG_INIT  = DW'(1 << (DW - 1));
  localparam logic        [WW-1:0]  DIF_INIT  = {1'b0, {(WW - 1){1'b1}}};
  localparam logic signed [CW-1:0]  CNT_INIT  = CW'(-15);
  localparam logic        [NSW-1:0] NSYMS_MAX = NSW'(1 << SW);

  dec_state_t         state_q, state_d;
  logic        [WW-1:0] dif_q, dif_d;
  logic        [DW-1:0] rng_q, rng_d;
  logic signed [CW-1:0] cnt_q, cnt_d;
  logic                 eos_q, eos_d;
  logic        [SW-1:0] ret_q, ret_d;
  logic        [SW-1:0] nm1_q, nm1_d;
  logic        [VW-1:0] u_q, u_d;
  logic        [SW-1:0] sym_out_q, sym_out_d;
  logic                 sym_valid_q, sym_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 req_ready_q, req_ready_d;

  logic signed [SHW-1:0]     s_full;
  logic                      refill_need;
  logic        [SHIFT_W-1:0] byte_sh;
  logic        [7:0]         byte_val;
  logic        [WW-1:0]      dif_refill;
  logic        [PW-1:0]      prod;
  logic        [VW-1:0]      v;
  logic                      hit;

  logic        [DW-1:0]      rng_n;
  logic        [WW-1:0]      dif_n;
  logic signed [CW-1:0]      cnt_n;
  logic        [SHIFT_W-1:0] d_n;

  arith_dec_renorm u_renorm (
    .rng_i (rng_q),
    .dif_i (dif_q),
    .cnt_i (cnt_q),
    .rng_o (rng_n),
    .dif_o (dif_n),
    .cnt_o (cnt_n),
    .d_o   (d_n)
  );

  // Refill shift and candidate threshold for the current search index.
  always_comb begin
    s_full      = SHW'(REFILL_TOP) - {cnt_q[CW-1], cnt_q};
    refill_need = !s_full[SHW-1];
    byte_sh     = SHIFT_W'(s_full);
    byte_val    = eos_q ? 8'h00 : in_byte;
    dif_refill  = dif_q ^ (WW'(byte_val) << byte_sh);
    prod        = PW'(rng_q >> 8) * PW'(cdf_data >> EC_PROB_SHIFT);
    v           = VW'(prod >> 1) + VW'(EC_MIN_PROB) * VW'(nm1_q - ret_q);
    // The last symbol is taken unconditionally; its icdf is 0 by construction.
    hit         = (VW'(dif_q[WW-1 -: DW]) >= v) || (ret_q == nm1_q);
  end

  // Next-state logic; init overrides every state.
  always_comb begin
    state_d     = state_q;
    dif_d       = dif_q;
    rng_d       = rng_q;
    cnt_d       = cnt_q;
    eos_d       = eos_q;
    ret_d       = ret_q;
    nm1_d       = nm1_q;
    u_d         = u_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = 1'b0;
    if (init) begin
      dif_d   = DIF_INIT;
      rng_d   = RNG_INIT;
      cnt_d   = CNT_INIT;
      eos_d   = 1'b0;
      ret_d   = '0;
      state_d = REFILL;
    end else begin
      case (state_q)
        IDLE: ;
        REFILL: begin
          if (!refill_need) begin
            state_d = READY;
          end else if (eos_q || in_valid) begin
            dif_d = dif_refill;
            cnt_d = cnt_q + CW'(8);
            if (!eos_q && in_last) eos_d = 1'b1;
            // After this byte cnt exceeds 8 exactly when cnt is currently positive.
            if (!cnt_q[CW-1] && (cnt_q != '0)) state_d = READY;
          end
        end
        READY: begin
          if (sym_req) begin
            nm1_d   = SW'(general_nsyms - NSW'(1));
            ret_d   = '0;
            u_d     = VW'(rng_q);
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            rng_d   = DW'(u_q - v);
            dif_d   = dif_q - (WW'(v) << (WW - DW));
            state_d = RENORM;
          end else begin
            u_d   = v;
            ret_d = ret_q + SW'(1);
          end
        end
        RENORM: begin
          rng_d       = rng_n;
          dif_d       = dif_n;
          cnt_d       = cnt_n;
          sym_out_d   = ret_q;
          sym_valid_d = 1'b1;
          state_d     = cnt_n[CW-1] ? REFILL : READY;
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = (state_d == REFILL) && !eos_d;
    req_ready_d = (state_d == READY);
  end

  // State and registered outputs.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dif_q       <= '0;
      rng_q       <= RNG_INIT;
      cnt_q       <= CNT_INIT;
      eos_q       <= 1'b0;
      ret_q       <= '0;
      nm1_q       <= '0;
      u_q         <= '0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dif_q       <= dif_d;
      rng_q       <= rng_d;
      cnt_q       <= cnt_d;
      eos_q       <= eos_d;
      ret_q       <= ret_d;
      nm1_q       <= nm1_d;
      u_q         <= u_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      in_ready_q  <= in_ready_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign req_ready = req_ready_q;
  assign cdf_addr  = ret_q;
  assign sym_out   = sym_out_q;
  assign sym_valid = sym_valid_q;

`ifdef ARITH_DECODER_DEBUG_EN
  // Observation copies, one cycle behind the internal state.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      RANGE_OUTPUT <= '0;
      DIF_OUTPUT   <= '0;
      CNT_OUTPUT   <= '0;
    end else begin
      RANGE_OUTPUT <= rng_q;
      DIF_OUTPUT   <= dif_q;
      CNT_OUTPUT   <= {{(32 - CW){cnt_q[CW-1]}}, cnt_q};
    end
  end
`endif

  a_nsyms_legal: assert property (@(posedge general_clk) disable iff (!reset)
    (state_q == READY && sym_req && !init) |->
      (general_nsyms >= NSW'(2) && general_nsyms <= NSYMS_MAX));

  a_rng_nonzero: assert property (@(posedge general_clk) disable iff (!reset)
    (state_q == RENORM) |-> (d_n != SHIFT_W'(16)));

endmodule

// File: tb/tb_arithmetic_decoder.sv
module tb_arithmetic_decoder;

  logic        general_clk;
  logic        reset;
  logic        init;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        sym_req;
  logic [4:0]  general_nsyms;
  logic        req_ready;
  logic [3:0]  cdf_addr;
  logic [15:0] cdf_data;
  logic [3:0]  sym_out;
  logic        sym_valid;
`ifdef ARITH_DECODER_DEBUG_EN
  logic [15:0] range_dbg;
  logic [31:0] dif_dbg;
  logic [31:0] cnt_dbg;
`endif

  int vecs = 0;
  int errs = 0;
  logic [15:0] icdf_tab [16];

  arithmetic_decoder dut (
    .general_clk   (general_clk),
    .reset         (reset),
    .init          (init),
    .in_byte       (in_byte),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .sym_req       (sym_req),
    .general_nsyms (general_nsyms),
    .req_ready     (req_ready),
    .cdf_addr      (cdf_addr),
    .cdf_data      (cdf_data),
    .sym_out       (sym_out),
    .sym_valid     (sym_valid)
`ifdef ARITH_DECODER_DEBUG_EN
    ,
    .RANGE_OUTPUT  (range_dbg),
    .DIF_OUTPUT    (dif_dbg),
    .CNT_OUTPUT    (cnt_dbg)
`endif
  );

  initial general_clk = 1'b0;
  always #5 general_clk = ~general_clk;

  always_comb cdf_data = icdf_tab[cdf_addr];

  task automatic tick();
    @(posedge general_clk);
    #1;
  endtask

  task automatic load_icdf(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3);
    for (int i = 0; i < 16; i++) icdf_tab[i] = 16'h0000;
    icdf_tab[0] = a0;
    icdf_tab[1] = a1;
    icdf_tab[2] = a2;
    icdf_tab[3] = a3;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Issues one request and counts cycles (accept edge included) until sym_valid.
  task automatic decode(input logic [4:0] n, output int cyc, output logic [3:0] sym);
    general_nsyms = n;
    sym_req = 1'b1;
    tick();
    sym_req = 1'b0;
    cyc = 1;
    while (sym_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    sym = sym_out;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    sym_req = 1'b0; general_nsyms = 5'd2;
    load_icdf(16'h0, 16'h0, 16'h0, 16'h0);
    #12;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    vecs++; if (sym_valid !== 1'b0) begin errs++; $display("FAIL rst_sym_valid: got %b want 0", sym_valid); end
    vecs++; if (sym_out !== 4'h0) begin errs++; $display("FAIL rst_sym_out: got %h want 0", sym_out); end
    vecs++; if (dut.rng_q !== 16'h8000) begin errs++; $display("FAIL rst_rng: got %h want 8000", dut.rng_q); end
    vecs++; if (dut.cnt_q !== 8'hF1) begin errs++; $display("FAIL rst_cnt: got %h want f1", dut.cnt_q); end
    vecs++; if (dut.dif_q !== 32'h0) begin errs++; $display("FAIL rst_dif: got %h want 0", dut.dif_q); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_stream();
    do_init();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL zero_init_in_ready: got %b want 1", in_ready); end
    vecs++; if (dut.dif_q !== 32'h7FFFFFFF) begin errs++; $display("FAIL zero_init_dif: got %h want 7fffffff", dut.dif_q); end
    for (int i = 0; i < 3; i++) begin
      feed(8'h00);
      if (i < 2) begin
        vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL zero_early_ready[%0d]: got %b want 0", i, req_ready); end
      end
    end
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL zero_req_ready: got %b want 1", req_ready); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL zero_in_ready: got %b want 0", in_ready); end
    vecs++; if (dut.cnt_q !== 8'h09) begin errs++; $display("FAIL zero_cnt: got %h want 09", dut.cnt_q); end
    vecs++; if (dut.dif_q !== 32'h7FFFFFFF) begin errs++; $display("FAIL zero_dif: got %h want 7fffffff", dut.dif_q); end
  endtask

  task automatic test_decode_a();
    int cyc;
    logic [3:0] sym;
    load_icdf(16'd16384, 16'd0, 16'd0, 16'd0);
    decode(5'd2, cyc, sym);
    vecs++; if (cyc !== 3) begin errs++; $display("FAIL decA_latency: got %0d want 3", cyc); end
    vecs++; if (sym !== 4'd0) begin errs++; $display("FAIL decA_sym: got %0d want 0", sym); end
    vecs++; if (dut.rng_q !== 16'hFFF0) begin errs++; $display("FAIL decA_rng: got %h want fff0", dut.rng_q); end
    vecs++; if (dut.dif_q !== 32'hFFEFFFFF) begin errs++; $display("FAIL decA_dif: got %h want ffefffff", dut.dif_q); end
    vecs++; if (dut.cnt_q !== 8'h07) begin errs++; $display("FAIL decA_cnt: got %h want 07", dut.cnt_q); end
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL decA_req_ready: got %b want 1", req_ready); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL decA_in_ready: got %b want 0", in_ready); end
    tick();
    vecs++; if (sym_valid !== 1'b0) begin errs++; $display("FAIL decA_pulse: got %b want 0", sym_valid); end
  endtask

  task automatic test_ones_stream();
    int cyc;
    logic [3:0] sym;
    do_init();
    for (int i = 0; i < 3; i++) feed(8'hFF);
    vecs++; if (dut.dif_q !== 32'h0000007F) begin errs++; $display("FAIL ones_dif: got %h want 0000007f", dut.dif_q); end
    load_icdf(16'd24576, 16'd16384, 16'd8192, 16'd0);
    decode(5'd4, cyc, sym);
    vecs++; if (cyc !== 6) begin errs++; $display("FAIL ones_latency: got %0d want 6", cyc); end
    vecs++; if (sym !== 4'd3) begin errs++; $display("FAIL ones_sym: got %0d want 3", sym); end
    vecs++; if (dut.rng_q !== 16'h8010) begin errs++; $display("FAIL ones_rng: got %h want 8010", dut.rng_q); end
    vecs++; if (dut.dif_q !== 32'h000001FF) begin errs++; $display("FAIL ones_dif2: got %h want 000001ff", dut.dif_q); end
    vecs++; if (dut.cnt_q !== 8'h07) begin errs++; $display("FAIL ones_cnt: got %h want 07", dut.cnt_q); end
  endtask

  task automatic test_renorm_refill();
    int cyc;
    logic [3:0] sym;
    do_init();
    for (int i = 0; i < 3; i++) feed(8'h00);
    load_icdf(16'd32704, 16'd0, 16'd0, 16'd0);
    decode(5'd2, cyc, sym);
    vecs++; if (cyc !== 3) begin errs++; $display("FAIL rr_latency: got %0d want 3", cyc); end
    vecs++; if (sym !== 4'd0) begin errs++; $display("FAIL rr_sym: got %0d want 0", sym); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rr_in_ready: got %b want 1", in_ready); end
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rr_req_ready: got %b want 0", req_ready); end
    vecs++; if (dut.rng_q !== 16'hF000) begin errs++; $display("FAIL rr_rng: got %h want f000", dut.rng_q); end
    vecs++; if (dut.dif_q !== 32'hEFFFFFFF) begin errs++; $display("FAIL rr_dif: got %h want efffffff", dut.dif_q); end
    vecs++; if (dut.cnt_q !== 8'hFF) begin errs++; $display("FAIL rr_cnt: got %h want ff", dut.cnt_q); end
    feed(8'h01);
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rr_mid_ready: got %b want 0", req_ready); end
    feed(8'h02);
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rr_end_ready: got %b want 1", req_ready); end
    vecs++; if (dut.cnt_q !== 8'h0F) begin errs++; $display("FAIL rr_cnt2: got %h want 0f", dut.cnt_q); end
    vecs++; if (dut.dif_q !== 32'hEFFFFDFB) begin errs++; $display("FAIL rr_dif2: got %h want effffdfb", dut.dif_q); end
  endtask

  task automatic test_backpressure();
    do_init();
    feed(8'h12);
    vecs++; if (dut.dif_q !== 32'h76FFFFFF) begin errs++; $display("FAIL bp_dif1: got %h want 76ffffff", dut.dif_q); end
    general_nsyms = 5'd2;
    sym_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_in_ready[%0d]: got %b want 1", i, in_ready); end
      vecs++; if (dut.dif_q !== 32'h76FFFFFF || req_ready !== 1'b0) begin
        errs++; $display("FAIL bp_hold[%0d]: got dif %h rdy %b want 76ffffff 0", i, dut.dif_q, req_ready);
      end
    end
    sym_req = 1'b0;
    feed(8'h34);
    feed(8'h56);
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL bp_req_ready: got %b want 1", req_ready); end
    vecs++; if (dut.dif_q !== 32'h76E5D4FF) begin errs++; $display("FAIL bp_dif: got %h want 76e5d4ff", dut.dif_q); end
    vecs++; if (dut.cnt_q !== 8'h09) begin errs++; $display("FAIL bp_cnt: got %h want 09", dut.cnt_q); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (sym_valid !== 1'b0 || req_ready !== 1'b1) begin
        errs++; $display("FAIL bp_no_queue[%0d]: got valid %b rdy %b want 0 1", i, sym_valid, req_ready);
      end
    end
  endtask

  task automatic test_eos();
    do_init();
    in_valid = 1'b1; in_byte = 8'hAB; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL eos_in_ready: got %b want 0", in_ready); end
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL eos_ready1: got %b want 0", req_ready); end
    tick();
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL eos_ready2: got %b want 0", req_ready); end
    tick();
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL eos_ready3: got %b want 1", req_ready); end
    vecs++; if (dut.dif_q !== 32'h2A7FFFFF) begin errs++; $display("FAIL eos_dif: got %h want 2a7fffff", dut.dif_q); end
    vecs++; if (dut.cnt_q !== 8'h09) begin errs++; $display("FAIL eos_cnt: got %h want 09", dut.cnt_q); end
  endtask

  task automatic test_init_abort();
    int cyc;
    logic [3:0] sym;
    load_icdf(16'd24576, 16'd16384, 16'd8192, 16'd0);
    general_nsyms = 5'd4;
    sym_req = 1'b1;
    tick();
    sym_req = 1'b0;
    tick();
    vecs++; if (cdf_addr !== 4'd1) begin errs++; $display("FAIL abort_addr: got %0d want 1", cdf_addr); end
    do_init();
    vecs++; if (in_ready !== 1'b1 || req_ready !== 1'b0 || sym_valid !== 1'b0) begin
      errs++; $display("FAIL abort_state: got in %b rdy %b valid %b want 1 0 0", in_ready, req_ready, sym_valid);
    end
    vecs++; if (cdf_addr !== 4'd0) begin errs++; $display("FAIL abort_addr0: got %0d want 0", cdf_addr); end
    for (int i = 0; i < 3; i++) begin
      feed(8'h00);
      vecs++; if (sym_valid !== 1'b0) begin errs++; $display("FAIL abort_no_valid[%0d]: got %b want 0", i, sym_valid); end
    end
    vecs++; if (dut.dif_q !== 32'h7FFFFFFF || dut.cnt_q !== 8'h09) begin
      errs++; $display("FAIL abort_refill: got dif %h cnt %h want 7fffffff 09", dut.dif_q, dut.cnt_q);
    end
    load_icdf(16'd16384, 16'd0, 16'd0, 16'd0);
    decode(5'd2, cyc, sym);
    vecs++; if (cyc !== 3 || sym !== 4'd0) begin errs++; $display("FAIL abort_decA: got cyc %0d sym %0d want 3 0", cyc, sym); end
    vecs++; if (dut.rng_q !== 16'hFFF0) begin errs++; $display("FAIL abort_decA_rng: got %h want fff0", dut.rng_q); end
  endtask

  task automatic test_async_reset();
    int cyc;
    logic [3:0] sym;
    do_init();
    for (int i = 0; i < 3; i++) feed(8'hFF);
    load_icdf(16'd24576, 16'd16384, 16'd8192, 16'd0);
    decode(5'd4, cyc, sym);
    general_nsyms = 5'd4;
    sym_req = 1'b1;
    tick();
    sym_req = 1'b0;
    tick();
    vecs++; if (cdf_addr !== 4'd1 || sym_out !== 4'd3) begin
      errs++; $display("FAIL ar_pre: got addr %0d sym %0d want 1 3", cdf_addr, sym_out);
    end
    #2;
    reset = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b0 || req_ready !== 1'b0 || sym_valid !== 1'b0) begin
      errs++; $display("FAIL ar_ctrl: got in %b rdy %b valid %b want 0 0 0", in_ready, req_ready, sym_valid);
    end
    vecs++; if (sym_out !== 4'd0 || cdf_addr !== 4'd0) begin
      errs++; $display("FAIL ar_data: got sym %0d addr %0d want 0 0", sym_out, cdf_addr);
    end
    vecs++; if (dut.rng_q !== 16'h8000 || dut.cnt_q !== 8'hF1 || dut.dif_q !== 32'h0) begin
      errs++; $display("FAIL ar_regs: got rng %h cnt %h dif %h want 8000 f1 0", dut.rng_q, dut.cnt_q, dut.dif_q);
    end
    tick();
    reset = 1'b1;
    tick();
    do_init();
    for (int i = 0; i < 3; i++) feed(8'h00);
    load_icdf(16'd16384, 16'd0, 16'd0, 16'd0);
    decode(5'd2, cyc, sym);
    vecs++; if (cyc !== 3 || sym !== 4'd0) begin errs++; $display("FAIL ar_decA: got cyc %0d sym %0d want 3 0", cyc, sym); end
    vecs++; if (dut.rng_q !== 16'hFFF0 || dut.dif_q !== 32'hFFEFFFFF) begin
      errs++; $display("FAIL ar_decA_state: got rng %h dif %h want fff0 ffefffff", dut.rng_q, dut.dif_q);
    end
  endtask

  initial begin
    test_reset();
    test_zero_stream();
    test_decode_a();
    test_ones_stream();
    test_renorm_refill();
    test_backpressure();
    test_eos();
    test_init_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
